da_coef_loader: RTL and testbench
=================================

DA_COEF_LOADER -- requirements
Module: da_coef_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-002 Port clk, input, 1: the only clock.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port coef_in, input, 16: signed two's-complement tap coefficient.
REQ-005 Port coef_valid, input, 1: coef_in is valid this cycle.
REQ-006 Port coef_ready, output, 1: the block accepts coef_in this cycle.
REQ-007 Port CIN, output, 20: signed LUT word to the DA coefficient memory.
REQ-008 Port CADDR, output, 11: LUT address {group[2:0], a[7:0]}.
REQ-009 Port CLOAD, output, 1: write strobe; CIN and CADDR are valid while it is high.
REQ-010 Port busy, output, 1: high in WRITE.
REQ-011 Port done, output, 1: one-cycle pulse after the last LUT write.

Function
REQ-012 The block SHALL have three states: COLLECT, WRITE and DONE.
REQ-013 COLLECT: coef_ready=1; each cycle with coef_valid&&coef_ready, coef_in SHALL be stored as tap[k], and k SHALL increment from 0; tap 0 arrives first.
REQ-014 Gaps in coef_valid SHALL stall collection without loss or duplication of taps.
REQ-015 Acceptance of tap 63 SHALL move the state to WRITE on the next edge, with coef_ready=0 from that edge.
REQ-016 WRITE: CLOAD=1 for exactly 2048 consecutive cycles, with write index w running 0..2047 and CADDR=w.
REQ-017 For CADDR={g,a}: CIN = sum over i=0..7 of (a[i] ? tap[8g+i] : 0), with each tap sign-extended to 20 bits; 16 bits plus 3 bits of growth means no overflow is possible.
REQ-018 CIN and CADDR SHALL be registered outputs; the first write (CADDR=0, CIN=0) SHALL appear on the cycle the state enters WRITE.
REQ-019 When w=2047 completes, the state SHALL go to DONE: CLOAD=0 and done=1 for one cycle, then back to COLLECT with k=0.
REQ-020 In WRITE and DONE, coef_valid SHALL be ignored and no tap SHALL be modified.
REQ-021 When CLOAD=0, CIN and CADDR SHALL hold their last values.

Reset
REQ-022 While reset is high, the state SHALL go to COLLECT, with k=0, w=0, CLOAD=0, busy=0, done=0, CIN=0, CADDR=0 and coef_ready=1 from the next edge.
REQ-023 Reset SHALL take priority over every other event, including coef_valid in the same cycle.
REQ-024 Reset in mid-WRITE SHALL abort the writes immediately, with no done pulse; the stored taps need not be cleared.

Configuration
REQ-025 When the macro DA_COEF_SYM_EN is defined, the block SHALL accept only 32 taps (k 0..31), set tap[63-k]=tap[k], and enter WRITE after tap 31.
REQ-026 When DA_COEF_SYM_EN is undefined, the block SHALL accept 64 taps.
REQ-027 The WRITE phase SHALL be identical with and without DA_COEF_SYM_EN.

Structure
REQ-028 The shared package SHALL hold the constants NUM_TAPS=64, TAPS_PER_GROUP=8, COEF_W=16, LUT_W=20 and ADDR_W=11, and the state encoding.
REQ-029 One sub-module, da_lut_sum, SHALL form the combinational 8-input masked signed sum (eight 16-bit taps plus an 8-bit mask in, 20-bit sum out).

Verification
REQ-030 All 64 taps = 1: CIN at CADDR 0x0FF = 8, at 0x000 = 0, at 0x355 = 4; CLOAD is high for exactly 2048 cycles; done pulses once.
REQ-031 All taps = -32768: CIN at 0x7FF = 20'hC0000, and at 0x701 = 20'hF8000.
REQ-032 tap[9]=5, all other taps 0: CIN at 0x102 = 5, at 0x101 = 0, at 0x1FF = 5; every address with group != 1 gives CIN = 0.
REQ-033 Random coef_valid gaps (50%) while loading taps k=k: the LUT contents match the gap-free run bit-exactly; coef_ready=0 throughout WRITE.
REQ-034 Reset asserted on write 1000: CLOAD=0 and coef_ready=1 on the next edge, no done pulse; a fresh 64-tap load then completes normally.
REQ-035 With DA_COEF_SYM_EN defined and 32 taps tap[k]=k+1: WRITE starts after 32 accepts; CIN at 0x780 = 1 (tap 63 mirrors tap 0).

Source files
------------

// File: rtl/da_coef_loader_pkg.sv
// rtl/da_coef_loader_pkg.sv - shared constants, state encoding and helpers for the DA coefficient loader
package da_coef_loader_pkg;

    localparam int NUM_TAPS       = 64;
    localparam int TAPS_PER_GROUP = 8;
    localparam int COEF_W         = 16;
    localparam int LUT_W          = 20;
    localparam int ADDR_W         = 11;

    // Address split: {group, mask}; the mask selects taps inside one group.
    localparam int MASK_W  = TAPS_PER_GROUP;
    localparam int GROUP_W = ADDR_W - MASK_W;
    localparam int K_W     = 6;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_WRITE   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Index of the tap that mirrors tap k in a symmetric filter.
    function automatic logic [K_W-1:0] mirror_idx(input logic [K_W-1:0] k);
        return K_W'(NUM_TAPS - 1) - k;
    endfunction

    // Sign-extend one coefficient to LUT width.
    function automatic logic [LUT_W-1:0] sext_coef(input logic [COEF_W-1:0] c);
        return {{(LUT_W - COEF_W){c[COEF_W-1]}}, c};
    endfunction

endpackage

// File: rtl/da_coef_loader_if.sv
// rtl/da_coef_loader_if.sv - coefficient input handshake and LUT write bus of the DA coefficient loader
interface da_coef_loader_if;
    import da_coef_loader_pkg::*;

    logic [COEF_W-1:0] coef_in;
    logic              coef_valid;
    logic              coef_ready;
    logic [LUT_W-1:0]  CIN;
    logic [ADDR_W-1:0] CADDR;
    logic              CLOAD;
    logic              busy;
    logic              done;

    // Loader side: consumes coefficients, drives the LUT write port and status.
    modport slave (
        input  coef_in,
        input  coef_valid,
        output coef_ready,
        output CIN,
        output CADDR,
        output CLOAD,
        output busy,
        output done
    );

    // Environment side: supplies coefficients, observes the LUT write port.
    modport master (
        output coef_in,
        output coef_valid,
        input  coef_ready,
        input  CIN,
        input  CADDR,
        input  CLOAD,
        input  busy,
        input  done
    );

endinterface

// File: rtl/da_lut_sum.sv
// rtl/da_lut_sum.sv - combinational masked signed sum of one group of eight taps
module da_lut_sum
    import da_coef_loader_pkg::*;
(
    input  logic [TAPS_PER_GROUP-1:0][COEF_W-1:0] taps,
    input  logic [TAPS_PER_GROUP-1:0]             mask,
    output logic [LUT_W-1:0]                      sum
);

    // Add every tap whose mask bit is set; growth of 3 bits cannot overflow.
    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS_PER_GROUP; i++) begin
            if (mask[i]) begin
                sum = sum + sext_coef(taps[i]);
            end
        end
    end

endmodule

// File: rtl/da_coef_loader.sv
// rtl/da_coef_loader.sv - collects FIR taps then writes all 2048 DA LUT words; DA_COEF_SYM_EN selects 32-tap symmetric load
module da_coef_loader
    import da_coef_loader_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    da_coef_loader_if.slave bus
);

`ifdef DA_COEF_SYM_EN
    localparam logic [K_W-1:0] LAST_K = K_W'(NUM_TAPS / 2 - 1);
`else
    localparam logic [K_W-1:0] LAST_K = K_W'(NUM_TAPS - 1);
`endif

    state_t            state;
    logic [K_W-1:0]    k;
    logic [COEF_W-1:0] taps [NUM_TAPS];

    logic [ADDR_W-1:0] caddr_q;
    logic [LUT_W-1:0]  cin_q;
    logic              cload_q;
    logic              busy_q;
    logic              done_q;
    logic              ready_q;

    logic              accept;
    logic [ADDR_W-1:0] next_addr;
    logic [GROUP_W-1:0] next_group;
    logic [TAPS_PER_GROUP-1:0][COEF_W-1:0] grp_taps;
    logic [LUT_W-1:0]  next_sum;

    // ready_q is only high in COLLECT, so it alone qualifies a tap accept.
    assign accept     = ready_q && bus.coef_valid;

    // The LUT word registered next cycle belongs to the address after the current one.
    assign next_addr  = caddr_q + ADDR_W'(1);
    assign next_group = next_addr[ADDR_W-1:MASK_W];

    // Gather the eight taps of the group addressed by next_addr.
    always_comb begin
        for (int i = 0; i < TAPS_PER_GROUP; i++) begin
            grp_taps[i] = taps[{next_group, i[GROUP_W-1:0]}];
        end
    end

    da_lut_sum u_lut_sum (
        .taps (grp_taps),
        .mask (next_addr[MASK_W-1:0]),
        .sum  (next_sum)
    );

    // Tap storage; not cleared by reset, only written on accepted coefficients.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            taps[k] <= bus.coef_in;
`ifdef DA_COEF_SYM_EN
            taps[mirror_idx(k)] <= bus.coef_in;
`endif
        end
    end

    // Control FSM with registered handshake, status and LUT write outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_COLLECT;
            k       <= '0;
            caddr_q <= '0;
            cin_q   <= '0;
            cload_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        if (k == LAST_K) begin
                            // Address 0 has an empty mask, so its word is always zero.
                            state   <= ST_WRITE;
                            ready_q <= 1'b0;
                            cload_q <= 1'b1;
                            busy_q  <= 1'b1;
                            caddr_q <= '0;
                            cin_q   <= '0;
                        end else begin
                            k <= k + K_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (caddr_q == LAST_ADDR) begin
                        state   <= ST_DONE;
                        cload_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        caddr_q <= next_addr;
                        cin_q   <= next_sum;
                    end
                end
                ST_DONE: begin
                    state   <= ST_COLLECT;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    k       <= '0;
                end
                default: begin
                    state   <= ST_COLLECT;
                    k       <= '0;
                    cload_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.coef_ready = ready_q;
    assign bus.CIN        = cin_q;
    assign bus.CADDR      = caddr_q;
    assign bus.CLOAD      = cload_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_da_coef_loader.sv
// tb/tb_da_coef_loader.sv - randomized self-checking bench for da_coef_loader against a LUT reference model
module tb_da_coef_loader;
    import da_coef_loader_pkg::*;

`ifdef DA_COEF_SYM_EN
    localparam int N_LOAD = 32;
`else
    localparam int N_LOAD = 64;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    da_coef_loader_if bus ();

    da_coef_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int load_tap  [64];
    int model_tap [64];
    logic [19:0] lut_seen [2048];
    logic [19:0] lut_ref  [2048];

    int exp_w;
    int cload_cnt;
    int done_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected LUT word: masked sum of the addressed group's taps.
    function automatic logic [19:0] lut_val(input int addr);
        int s;
        int g;
        s = 0;
        g = addr / 256;
        for (int i = 0; i < 8; i++) begin
            if (((addr >> i) & 1) == 1) s += model_tap[8 * g + i];
        end
        return s[19:0];
    endfunction

    // Reference tap set as the loader must hold it after a load.
    task automatic set_model();
        for (int i = 0; i < 64; i++) model_tap[i] = load_tap[i];
`ifdef DA_COEF_SYM_EN
        for (int i = 0; i < 32; i++) model_tap[63 - i] = load_tap[i];
`endif
    endtask

    // Per-cycle compare of the write stream and status against the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.CLOAD) begin
                check("caddr_seq", 32'(bus.CADDR), 32'(exp_w));
                check("cin", 32'(bus.CIN), 32'(lut_val(int'(bus.CADDR))));
                check("ready_in_write", 32'(bus.coef_ready), 32'd0);
                lut_seen[bus.CADDR] = bus.CIN;
                exp_w++;
                cload_cnt++;
            end
            check("busy_eq_cload", 32'(bus.busy), 32'(bus.CLOAD));
            if (bus.done) begin
                done_cnt++;
                check("done_no_cload", 32'(bus.CLOAD), 32'd0);
            end
        end
    end

    task automatic load(input int gap_pct);
        int  k;
        int  guard;
        bit  valid;
        logic rdy;
        logic signed [15:0] junk;
        set_model();
        exp_w = 0;
        cload_cnt = 0;
        done_cnt = 0;
        for (int a = 0; a < 2048; a++) lut_seen[a] = '1;
        k = 0;
        guard = 0;
        while (k < N_LOAD && guard < 5000) begin
            valid = ($urandom_range(99) >= gap_pct);
            junk = 16'($urandom);
            bus.coef_valid = valid;
            bus.coef_in = valid ? 16'(load_tap[k]) : junk;
            rdy = bus.coef_ready;
            @(posedge clk);
            #1;
            guard++;
            if (valid && rdy === 1'b1) k++;
        end
        bus.coef_valid = 1'b0;
        check("load_accept_count", 32'(k), 32'(N_LOAD));
        check("write_start_cload", 32'(bus.CLOAD), 32'd1);
        check("write_start_busy", 32'(bus.busy), 32'd1);
        check("write_start_caddr", 32'(bus.CADDR), 32'd0);
        check("write_start_cin", 32'(bus.CIN), 32'd0);
        check("write_start_ready", 32'(bus.coef_ready), 32'd0);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (bus.done !== 1'b1 && guard < 2200) begin
            bus.coef_valid = 1'($urandom);
            bus.coef_in = 16'($urandom);
            @(posedge clk);
            #1;
            guard++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
        check("cload_cycles", 32'(cload_cnt), 32'd2048);
        @(posedge clk);
        #1;
        bus.coef_valid = 1'b0;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("ready_after_done", 32'(bus.coef_ready), 32'd1);
        check("done_pulses", 32'(done_cnt), 32'd1);
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < 64; i++) load_tap[i] = v;
    endtask

    task automatic fill_random();
        logic signed [15:0] r;
        for (int i = 0; i < 64; i++) begin
            r = 16'($urandom);
            load_tap[i] = r;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int diffs;
        int nz;
        reset = 1'b1;
        bus.coef_valid = 1'b1;
        bus.coef_in = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cload", 32'(bus.CLOAD), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_cin", 32'(bus.CIN), 32'd0);
        check("rst_caddr", 32'(bus.CADDR), 32'd0);
        check("rst_ready", 32'(bus.coef_ready), 32'd1);
        bus.coef_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;

        fill_const(1);
        load(0);
        wait_done();
        check("ones_0ff", 32'(lut_seen[11'h0FF]), 32'd8);
        check("ones_000", 32'(lut_seen[11'h000]), 32'd0);
        check("ones_355", 32'(lut_seen[11'h355]), 32'd4);

        fill_const(-32768);
        load(0);
        wait_done();
        check("neg_7ff", 32'(lut_seen[11'h7FF]), 32'h000C0000);
        check("neg_701", 32'(lut_seen[11'h701]), 32'h000F8000);

`ifdef DA_COEF_SYM_EN
        for (int i = 0; i < 64; i++) load_tap[i] = (i < 32) ? i + 1 : 0;
        load(20);
        wait_done();
        check("sym_780", 32'(lut_seen[11'h780]), 32'd1);
`else
        fill_const(0);
        load_tap[9] = 5;
        load(0);
        wait_done();
        check("t9_102", 32'(lut_seen[11'h102]), 32'd5);
        check("t9_101", 32'(lut_seen[11'h101]), 32'd0);
        check("t9_1ff", 32'(lut_seen[11'h1FF]), 32'd5);
        nz = 0;
        for (int a = 0; a < 2048; a++) begin
            if ((a / 256) != 1 && lut_seen[a] != 20'd0) nz++;
        end
        check("t9_other_groups_zero", 32'(nz), 32'd0);
`endif

        for (int i = 0; i < 64; i++) load_tap[i] = i;
        load(0);
        wait_done();
        for (int a = 0; a < 2048; a++) lut_ref[a] = lut_seen[a];
        load(50);
        wait_done();
        diffs = 0;
        for (int a = 0; a < 2048; a++) if (lut_seen[a] !== lut_ref[a]) diffs++;
        check("gap_lut_match", 32'(diffs), 32'd0);

        fill_random();
        load(30);
        wait_done();

        fill_random();
        load(10);
        begin
            int guard;
            guard = 0;
            while (!(bus.CLOAD === 1'b1 && bus.CADDR == 11'd1000) && guard < 1200) begin
                @(posedge clk);
                #1;
                guard++;
            end
            check("reach_write_1000", 32'(bus.CADDR), 32'd1000);
        end
        reset = 1'b1;
        bus.coef_valid = 1'b1;
        bus.coef_in = 16'h7777;
        @(posedge clk);
        #1;
        check("abort_cload", 32'(bus.CLOAD), 32'd0);
        check("abort_ready", 32'(bus.coef_ready), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        bus.coef_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'd0);

        fill_random();
        load(40);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
